// File: rtl/serial_frame_sequencer_if.sv
// Word-in / bit-out port bundle for the serial frame sequencer.
// The source drives the valid word and bit tick; the sequencer returns ready, the line, and its status.
interface serial_frame_sequencer_if #(
  parameter int WIDTH = 4
);
  logic             i_vld;
  logic [WIDTH-1:0] i_dat;
  logic             o_rdy;
  logic             i_en;
  logic             o_so;
  logic             o_busy;
  logic             o_done;
  logic [1:0]       o_state;

  modport master (
    output i_vld, i_dat, i_en,
    input  o_rdy, o_so, o_busy, o_done, o_state
  );

  modport slave (
    input  i_vld, i_dat, i_en,
    output o_rdy, o_so, o_busy, o_done, o_state
  );
endinterface

// File: rtl/serial_frame_sequencer.sv
// Serializes each accepted word as start(0), WIDTH data bits, stop(1); first SO change 1 cycle after handshake.
// Ready only in IDLE (including the DONE cycle); every bit period is held until the next i_en tick.
module serial_frame_sequencer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic                 i_clk,
  input logic                 i_rst_n,
  serial_frame_sequencer_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_nxt;
  logic [WIDTH-1:0] w_shift_adv;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             r_so;
  logic             w_so_nxt;
  logic             r_done;
  logic             w_done_nxt;

  // The outgoing end sits at the top for MSB-first and at bit 0 for LSB-first.
  assign w_shift_adv = MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0} : {1'b0, r_shift[WIDTH-1:1]};

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    w_so_nxt    = 1'b1;
    case (r_state)
      IDLE: begin
        if (bus.i_vld) begin
          w_state_nxt = START;
          w_shift_nxt = bus.i_dat;
          w_cnt_nxt   = '0;
        end
      end
      START: begin
        if (bus.i_en) w_state_nxt = DATA;
      end
      DATA: begin
        if (bus.i_en) begin
          w_shift_nxt = w_shift_adv;
          w_cnt_nxt   = r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH - 1)) w_state_nxt = STOP;
        end
      end
      STOP: begin
        if (bus.i_en) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // SO is registered from the next state so the line never glitches.
    case (w_state_nxt)
      START:   w_so_nxt = 1'b0;
      DATA:    w_so_nxt = MSB_FIRST ? w_shift_nxt[WIDTH-1] : w_shift_nxt[0];
      default: w_so_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_so    <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
      r_so    <= w_so_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign bus.o_rdy   = (r_state == IDLE);
  assign bus.o_busy  = (r_state != IDLE);
  assign bus.o_state = r_state;
  assign bus.o_so    = r_so;
  assign bus.o_done  = r_done;

endmodule

// File: tb/tb_serial_frame_sequencer.sv
// Bench for serial_frame_sequencer: vector table, hand-written corner sequences,
// and a random run against a frame-bit-list reference model for both bit orders.
module tb_serial_frame_sequencer;
  localparam int W = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  serial_frame_sequencer_if #(.WIDTH(W)) bm();
  serial_frame_sequencer_if #(.WIDTH(W)) bl();

  serial_frame_sequencer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bm.slave)
  );
  serial_frame_sequencer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bl.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       vld;
    logic [3:0] dat;
    logic       en;
    logic       so;
    logic [1:0] st;
    logic       done;
    logic       rdy;
  } vec_t;

  vec_t tbl[8];

  // reference model: position in the frame bit list, -1 when idle
  int         m_pos[2];
  logic [3:0] m_dat[2];
  logic       m_done[2];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input bit lsb, input logic v, input logic [3:0] d, input logic e);
    if (lsb) begin
      bl.i_vld = v; bl.i_dat = d; bl.i_en = e;
    end else begin
      bm.i_vld = v; bm.i_dat = d; bm.i_en = e;
    end
  endtask

  function automatic logic so_of(input bit lsb);
    return lsb ? bl.o_so : bm.o_so;
  endfunction

  function automatic logic done_of(input bit lsb);
    return lsb ? bl.o_done : bm.o_done;
  endfunction

  function automatic logic [1:0] st_of(input bit lsb);
    return lsb ? bl.o_state : bm.o_state;
  endfunction

  // j-th bit of the frame: 0 = start, W+1 = stop, else data in the chosen order
  function automatic logic frame_bit(input logic [3:0] d, input bit lsb, input int j);
    if (j == 0) return 1'b0;
    if (j == W + 1) return 1'b1;
    return lsb ? d[j-1] : d[W-j];
  endfunction

  task automatic frame_en1(input bit lsb, input logic [3:0] d, input logic [5:0] exp, input string nm);
    drv(lsb, 1'b1, d, 1'b1);
    cyc();
    drv(lsb, 1'b0, 4'h0, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      chk($sformatf("%s_so%0d", nm, k), 8'(so_of(lsb)), 8'(exp[k-1]));
      chk($sformatf("%s_done%0d", nm, k), 8'(done_of(lsb)), 8'h0);
      cyc();
    end
    chk($sformatf("%s_done7", nm), 8'(done_of(lsb)), 8'h1);
    cyc();
    chk($sformatf("%s_done8", nm), 8'(done_of(lsb)), 8'h0);
    chk($sformatf("%s_idle8", nm), 8'(st_of(lsb)), 8'h0);
    drv(lsb, 1'b0, 4'h0, 1'b0);
  endtask

  task automatic model_step(input bit lsb, input logic v, input logic [3:0] d, input logic e);
    int i;
    i = lsb ? 1 : 0;
    m_done[i] = 1'b0;
    if (m_pos[i] < 0) begin
      if (v) begin
        m_pos[i] = 0;
        m_dat[i] = d;
      end
    end else if (e) begin
      m_pos[i]++;
      if (m_pos[i] == W + 2) begin
        m_pos[i]  = -1;
        m_done[i] = 1'b1;
      end
    end
  endtask

  task automatic model_chk(input bit lsb, input int cyc_n);
    int         i;
    logic       e_so;
    logic [1:0] e_st;
    i = lsb ? 1 : 0;
    e_so = (m_pos[i] < 0) ? 1'b1 : frame_bit(m_dat[i], lsb, m_pos[i]);
    if (m_pos[i] < 0)       e_st = 2'b00;
    else if (m_pos[i] == 0) e_st = 2'b01;
    else if (m_pos[i] <= W) e_st = 2'b10;
    else                    e_st = 2'b11;
    chk($sformatf("rnd%0d_c%0d_so", i, cyc_n), 8'(so_of(lsb)), 8'(e_so));
    chk($sformatf("rnd%0d_c%0d_st", i, cyc_n), 8'(st_of(lsb)), 8'(e_st));
    chk($sformatf("rnd%0d_c%0d_done", i, cyc_n), 8'(done_of(lsb)), 8'(m_done[i]));
    chk($sformatf("rnd%0d_c%0d_rdy", i, cyc_n), 8'(lsb ? bl.o_rdy : bm.o_rdy), 8'(m_pos[i] < 0));
  endtask

  initial begin
    logic [12:0] bb;
    logic [5:0]  ex;
    logic        v;
    logic [3:0]  d;
    logic        e;

    // inputs applied before an edge, outputs expected in the following cycle
    tbl[0] = '{1'b1, 4'hB, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 4'h0, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 4'h0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 4'h0, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 4'h0, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 4'h0, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 4'h0, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1};
    tbl[7] = '{1'b0, 4'h0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1};

    drv(1'b0, 1'b0, 4'h0, 1'b0);
    drv(1'b1, 1'b0, 4'h0, 1'b0);

    // asynchronous reset with no clock edge
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst%0d_so", i), 8'(so_of(i[0])), 8'h1);
      chk($sformatf("rst%0d_st", i), 8'(st_of(i[0])), 8'h0);
      chk($sformatf("rst%0d_done", i), 8'(done_of(i[0])), 8'h0);
    end
    chk("rst_rdy", 8'(bm.o_rdy), 8'h1);
    chk("rst_busy", 8'(bm.o_busy), 8'h0);
    @(negedge clk) rst_n = 1'b1;
    cyc();

    for (int i = 0; i < 8; i++) begin
      drv(1'b0, tbl[i].vld, tbl[i].dat, tbl[i].en);
      cyc();
      chk($sformatf("tbl%0d_so", i), 8'(bm.o_so), 8'(tbl[i].so));
      chk($sformatf("tbl%0d_st", i), 8'(bm.o_state), 8'(tbl[i].st));
      chk($sformatf("tbl%0d_done", i), 8'(bm.o_done), 8'(tbl[i].done));
      chk($sformatf("tbl%0d_rdy", i), 8'(bm.o_rdy), 8'(tbl[i].rdy));
      chk($sformatf("tbl%0d_busy", i), 8'(bm.o_busy), 8'(!tbl[i].rdy));
    end
    drv(1'b0, 1'b0, 4'h0, 1'b0);
    cyc();

    // EN every third cycle: each frame bit held 3 cycles
    ex = 6'b111010;
    drv(1'b0, 1'b1, 4'hB, 1'b0);
    cyc();
    drv(1'b0, 1'b0, 4'h0, 1'b0);
    for (int k = 0; k <= 18; k++) begin
      if (k < 18) chk($sformatf("en3_so%0d", k), 8'(bm.o_so), 8'(ex[k/3]));
      chk($sformatf("en3_done%0d", k), 8'(bm.o_done), 8'(k == 18));
      bm.i_en = (k % 3 == 2);
      cyc();
    end
    drv(1'b0, 1'b0, 4'h0, 1'b0);
    cyc();

    // back-to-back frames, second handshake in the DONE cycle
    bb = 13'b1101001101010;
    drv(1'b0, 1'b1, 4'hA, 1'b1);
    cyc();
    bm.i_dat = 4'h5;
    for (int k = 1; k <= 14; k++) begin
      if (k <= 13) chk($sformatf("b2b_so%0d", k), 8'(bm.o_so), 8'(bb[k-1]));
      chk($sformatf("b2b_done%0d", k), 8'(bm.o_done), 8'(k == 7 || k == 14));
      if (k == 7) chk("b2b_rdy7", 8'(bm.o_rdy), 8'h1);
      if (k == 8) bm.i_vld = 1'b0;
      cyc();
    end
    chk("b2b_idle", 8'(bm.o_state), 8'h0);
    drv(1'b0, 1'b0, 4'h0, 1'b0);

    // valid pulse during DATA is ignored
    ex = 6'b111010;
    drv(1'b0, 1'b1, 4'hB, 1'b1);
    cyc();
    drv(1'b0, 1'b0, 4'h0, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      if (k <= 6) chk($sformatf("vbusy_so%0d", k), 8'(bm.o_so), 8'(ex[k-1]));
      if (k == 3) chk("vbusy_rdy3", 8'(bm.o_rdy), 8'h0);
      if (k == 7) chk("vbusy_done7", 8'(bm.o_done), 8'h1);
      if (k == 8) chk("vbusy_idle8", 8'(bm.o_state), 8'h0);
      bm.i_vld = (k == 3);
      bm.i_dat = (k == 3) ? 4'hF : 4'h0;
      cyc();
    end
    drv(1'b0, 1'b0, 4'h0, 1'b0);

    // reset during the second data bit
    drv(1'b0, 1'b1, 4'hA, 1'b1);
    cyc();
    drv(1'b0, 1'b0, 4'h0, 1'b1);
    cyc();
    cyc();
    chk("mid_so_pre", 8'(bm.o_so), 8'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_so", 8'(bm.o_so), 8'h1);
    chk("mid_st", 8'(bm.o_state), 8'h0);
    chk("mid_done", 8'(bm.o_done), 8'h0);
    @(negedge clk) rst_n = 1'b1;
    cyc();
    chk("mid_after_done", 8'(bm.o_done), 8'h0);
    chk("mid_after_st", 8'(bm.o_state), 8'h0);
    frame_en1(1'b0, 4'h3, 6'b111000, "post_rst");

    frame_en1(1'b1, 4'b0001, 6'b100010, "lsb");

    // random run, both bit orders against the model
    #2 rst_n = 1'b0;
    m_pos[0] = -1; m_pos[1] = -1;
    m_done[0] = 1'b0; m_done[1] = 1'b0;
    m_dat[0] = 4'h0; m_dat[1] = 4'h0;
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      v = ($urandom_range(0, 3) == 0);
      d = 4'($urandom);
      e = (c < 500) ? 1'b1 : 1'($urandom_range(0, 1));
      drv(1'b0, v, d, e);
      drv(1'b1, v, d, e);
      cyc();
      model_step(1'b0, v, d, e);
      model_step(1'b1, v, d, e);
      model_chk(1'b0, c);
      model_chk(1'b1, c);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
